// File: rtl/arbitro_rr_mux8_if.sv
// rtl/arbitro_rr_mux8_if.sv - request/grant and mux-select bundle for arbitro_rr_mux8
interface arbitro_rr_mux8_if;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic [2:0] sel;
   logic       busy;
   logic       timeout_evt;

   modport slave (
      input  req,
      input  done,
      output grant,
      output sel,
      output busy,
      output timeout_evt
   );

   modport master (
      output req,
      output done,
      input  grant,
      input  sel,
      input  busy,
      input  timeout_evt
   );
endinterface

// File: rtl/arbitro_rr_mux8.sv
// rtl/arbitro_rr_mux8.sv - round-robin arbiter driving the select of a shared 8:1 mux
// One owner at a time; a grant is always followed by at least one idle cycle.
module arbitro_rr_mux8 #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   arbitro_rr_mux8_if.slave bus
);
   localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

   typedef enum logic {LIVRE, OCUPADO} state_t;

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] grant_q, grant_d;
   logic [2:0] sel_q, sel_d;
   logic       tev_q, tev_d;

   logic [2:0] scan_idx;
   logic [2:0] winner;
   logic       found;
   logic       rel_user;
   logic       rel_to;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= LIVRE;
         ptr_q   <= 3'd0;
         cnt_q   <= 8'd0;
         grant_q <= 8'd0;
         sel_q   <= 3'd0;
         tev_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         tev_q   <= tev_d;
      end
   end

   // First requester at or after the pointer, wrapping mod 8.
   always_comb begin
      scan_idx = ptr_q;
      winner   = ptr_q;
      found    = 1'b0;
      for (int k = 0; k < 8; k++) begin
         scan_idx = ptr_q + 3'(k);
         if (!found && bus.req[scan_idx]) begin
            winner = scan_idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      grant_d  = grant_q;
      sel_d    = sel_q;
      tev_d    = 1'b0;
      rel_user = bus.done || !bus.req[sel_q];
      rel_to   = (TIMEOUT != 0) && (cnt_q == TO_LIM);

      case (state_q)
         LIVRE: begin
            grant_d = 8'd0;
            if (found) begin
               grant_d = 8'd1 << winner;
               sel_d   = winner;
               cnt_d   = 8'd1;
               state_d = OCUPADO;
            end
         end
         OCUPADO: begin
            if (rel_user || rel_to) begin
               grant_d = 8'd0;
               ptr_d   = sel_q + 3'd1;
               tev_d   = rel_to && !rel_user;
               state_d = LIVRE;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            grant_d = 8'd0;
            state_d = LIVRE;
         end
      endcase
   end

   assign bus.grant       = grant_q;
   assign bus.sel         = sel_q;
   assign bus.busy        = |grant_q;
   assign bus.timeout_evt = tev_q;
endmodule

// File: tb/tb_arbitro_rr_mux8.sv
// tb/tb_arbitro_rr_mux8.sv - directed self-checking bench for arbitro_rr_mux8
module tb_arbitro_rr_mux8;
   logic clock;
   logic reset_n;
   int   n_assert;
   int   n_fail;

   arbitro_rr_mux8_if ifa ();
   arbitro_rr_mux8_if ifb ();

   arbitro_rr_mux8 #(.TIMEOUT(4)) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (ifa)
   );

   arbitro_rr_mux8 #(.TIMEOUT(0)) u_dut0 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (ifb)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [7:0] g, input logic [2:0] s,
                        input logic b, input logic t);
      chk({tag, ".grant"}, 32'(ifa.grant), 32'(g));
      chk({tag, ".sel"}, 32'(ifa.sel), 32'(s));
      chk({tag, ".busy"}, 32'(ifa.busy), 32'(b));
      chk({tag, ".tev"}, 32'(ifa.timeout_evt), 32'(t));
   endtask

   initial begin
      logic [7:0] exp_g;
      logic       saw_tev;
      n_assert = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      ifa.req  = 8'h00;
      ifa.done = 1'b0;
      ifb.req  = 8'h00;
      ifb.done = 1'b0;

      tick();
      tick();
      chk_a("reset", 8'h00, 3'd0, 1'b0, 1'b0);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle.grant", 32'(ifa.grant), 32'h0);
      end

      // single request and done release
      ifa.req = 8'h20;
      tick();
      chk_a("single.grant", 8'h20, 3'd5, 1'b1, 1'b0);
      ifa.done = 1'b1;
      tick();
      chk_a("single.done", 8'h00, 3'd5, 1'b0, 1'b0);
      ifa.done = 1'b0;
      ifa.req  = 8'h00;
      tick();
      chk_a("single.idle", 8'h00, 3'd5, 1'b0, 1'b0);

      // pointer wrap: owner 6, then 6 and 0 request -> 0 wins
      ifa.req = 8'h40;
      tick();
      chk_a("wrap.own6", 8'h40, 3'd6, 1'b1, 1'b0);
      ifa.done = 1'b1;
      tick();
      chk_a("wrap.rel6", 8'h00, 3'd6, 1'b0, 1'b0);
      ifa.done = 1'b0;
      ifa.req  = 8'h41;
      tick();
      chk_a("wrap.win0", 8'h01, 3'd0, 1'b1, 1'b0);
      ifa.req = 8'h00;
      tick();
      chk_a("wrap.drop", 8'h00, 3'd0, 1'b0, 1'b0);

      // asynchronous reset mid-grant
      ifa.req = 8'hFF;
      tick();
      chk_a("prereset.grant", 8'h02, 3'd1, 1'b1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_a("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      reset_n = 1'b1;

      // round-robin with all requesting
      for (int i = 0; i < 9; i++) begin
         exp_g = 8'd1 << (i % 8);
         tick();
         chk("rr.grant1", 32'(ifa.grant), 32'(exp_g));
         chk("rr.sel", 32'(ifa.sel), 32'(i % 8));
         tick();
         chk("rr.grant2", 32'(ifa.grant), 32'(exp_g));
         ifa.done = 1'b1;
         tick();
         chk("rr.dead", 32'(ifa.grant), 32'h0);
         ifa.done = 1'b0;
      end
      ifa.req = 8'h00;
      tick();

      // timeout after exactly 4 cycles
      ifa.req = 8'h08;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_a("to.hold", 8'h08, 3'd3, 1'b1, 1'b0);
      end
      tick();
      chk_a("to.revoke", 8'h00, 3'd3, 1'b0, 1'b1);
      tick();
      chk_a("to.regrant", 8'h08, 3'd3, 1'b1, 1'b0);

      // done on the same edge as counter==TIMEOUT
      for (int i = 0; i < 3; i++) tick();
      chk("sim.hold", 32'(ifa.grant), 32'h08);
      ifa.done = 1'b1;
      tick();
      chk_a("sim.done_to", 8'h00, 3'd3, 1'b0, 1'b0);
      ifa.done = 1'b0;
      ifa.req  = 8'h00;
      tick();

      // owner drops while requester 2 rises
      ifa.req = 8'h08;
      tick();
      chk_a("drop.own3", 8'h08, 3'd3, 1'b1, 1'b0);
      ifa.req = 8'h04;
      tick();
      chk_a("drop.dead", 8'h00, 3'd3, 1'b0, 1'b0);
      tick();
      chk_a("drop.win2", 8'h04, 3'd2, 1'b1, 1'b0);
      ifa.req = 8'h00;
      tick();
      chk("drop.rel", 32'(ifa.grant), 32'h0);

      // TIMEOUT=0 never revokes
      ifb.req = 8'h10;
      tick();
      chk("nt.grant", 32'(ifb.grant), 32'h10);
      saw_tev = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (ifb.timeout_evt || ifb.grant != 8'h10) saw_tev = 1'b1;
      end
      chk("nt.held300", 32'(saw_tev), 32'h0);
      chk("nt.sel", 32'(ifb.sel), 32'd4);
      ifb.done = 1'b1;
      tick();
      chk("nt.rel", 32'(ifb.grant), 32'h0);
      chk("nt.tev", 32'(ifb.timeout_evt), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/arbitro_rr_mux8.md
Name: arbitro_rr_mux8

Overview:
- Round-robin arbiter/sequencer that shares one 8:1 one-bit multiplexer among 8 requesters.
- Grants exactly one requester at a time and drives the mux 3-bit select with the winner's index.
- Holds the grant until the owner signals done, drops its request, or times out.
- Sits between the requesting units and the mux select input in the ULA datapath.

Parameters:
TIMEOUT, 16, max consecutive cycles one owner may hold the grant; 0 disables the timeout; legal range 0..255.

Ports:
clock  input  1  single system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
req  input  8  request vector; bit i = requester i wants the mux.
done  input  1  current owner releases the mux this cycle.
grant  output  8  one-hot grant vector, registered.
sel  output  3  mux select = index of current or last owner, registered.
busy  output  1  1 while a grant is active.
timeout_evt  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (reset_n=0, asynchronous, any time): grant=0, sel=3'b000, busy=0, timeout_evt=0, state=LIVRE, priority pointer ptr=0, hold counter=0.
- A reset mid-grant drops the grant immediately, without waiting for a clock edge.
- States: LIVRE (no owner) and OCUPADO (owner holds the mux).
- LIVRE:
  - If req!=0, select the first set bit scanning ptr, ptr+1, …, 7, 0, … (mod 8).
  - On the next edge: grant=one-hot(winner), sel=winner, busy=1, counter=1, go to OCUPADO.
  - Grant latency is exactly 1 cycle from req being sampled in LIVRE.
  - If req==0, stay in LIVRE; grant=0, sel keeps its last value.
  - done is ignored in LIVRE.
- OCUPADO release conditions, evaluated every edge:
  - (a) done=1.
  - (b) req[owner]=0.
  - (c) TIMEOUT!=0 and counter==TIMEOUT.
  - On any of these, the next edge sets grant=0, busy=0, ptr=(owner+1) mod 8, state=LIVRE.
  - timeout_evt=1 for that one cycle only when (c) alone caused the release; (a) or (b) takes precedence and gives timeout_evt=0.
  - Otherwise the counter increments, saturating at 255, and grant/sel stay unchanged.
- Mandatory dead cycle: at least one cycle with grant=0 between successive grants, including when the same requester re-wins.
- sel changes only on the edge that asserts a new grant; it never changes during OCUPADO or LIVRE, so the mux output is glitch-free.
- Fairness: with all 8 requesting continuously, grants rotate 0,1,…,7,0, each owner getting one turn.
- Requests arriving while the mux is owned do not preempt the owner.
- Requests from non-owners that drop before arbitration are simply not considered.
- grant is always one-hot or zero; busy == |grant.
- Width rules:
  - ptr and sel are 3 bits; the scan index wraps mod 8.
  - The counter is 8 bits.
  - Comparison with TIMEOUT is unsigned.

Test Plan:
- Reset/idle: assert reset_n=0 with req=8'hFF mid-operation -> grant=0, sel=0, busy=0 immediately. After release with req=0 for 5 cycles -> grant stays 0.
- Single request: req=8'b0010_0000 in LIVRE -> next cycle grant=8'h20, sel=5, busy=1. Pulse done=1 -> next cycle grant=0, busy=0, timeout_evt=0, sel stays 5.
- Round-robin: req=8'hFF held, owner pulses done on its 2nd grant cycle -> grant sequence 8'h01,8'h02,…,8'h80,8'h01 with one zero cycle between each; sel sequence 0..7,0.
- Pointer wrap: last owner 6, then req=8'b0100_0001 -> next grant goes to requester 0 (scan 7,0), not 6.
- Timeout: TIMEOUT=4, req=8'h08 held, done=0 -> grant=8'h08 for exactly 4 cycles, then grant=0 with timeout_evt=1 for one cycle. Next grant to 3 comes after the dead cycle. With TIMEOUT=0 the grant holds ≥300 cycles.
- Simultaneous events: done=1 on the same edge counter==TIMEOUT -> release with timeout_evt=0. Owner drops req while req[2] rises -> one dead cycle, then grant=8'h04.
